// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire stage fed by the MAC result stream.
//
// Each accepted signed sample is integrated into a leaky membrane potential.
// When the potential reaches the runtime-loadable threshold the stage emits a
// one-cycle spike, reloads the potential and then refuses input for a
// refractory period.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-low reset
//   clken      in   1      clock enable; low freezes every register
//   in_valid   in   1      in_data valid
//   in_ready   out  1      stage can accept in_data this cycle
//   in_data    in   W      signed synaptic input
//   thr_ld     in   1      load thr_in into the threshold register
//   thr_in     in   W      new signed threshold
//   spike      out  1      one-cycle spike pulse
//   vmem       out  VW     signed membrane potential
//   state      out  2      00 INTEG, 01 FIRE, 10 REFRACT
//   spike_cnt  out  CNT_W  saturating spike count
module lif_neuron #(
  parameter int unsigned W          = 16,
  parameter int unsigned VW         = 20,
  parameter int          THRESH     = 1000,
  parameter int unsigned LEAK_SHIFT = 4,
  parameter int unsigned REFRAC     = 3,
  parameter int          V_RESET    = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  in_data,
  input  logic                 thr_ld,
  input  logic signed [W-1:0]  thr_in,
  output logic                 spike,
  output logic signed [VW-1:0] vmem,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     spike_cnt
);

  localparam int unsigned RCW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic [RCW-1:0]       REFRAC_INIT = RCW'(REFRAC);
  localparam logic signed [W-1:0]  THR_RST     = W'(THRESH);
  localparam logic signed [VW-1:0] V_RST       = VW'(V_RESET);
  localparam logic signed [VW-1:0] V_MAX       = {1'b0, {(VW-1){1'b1}}};
  localparam logic signed [VW-1:0] V_MIN       = {1'b1, {(VW-1){1'b0}}};

  typedef enum logic [1:0] {
    StInteg   = 2'b00,
    StFire    = 2'b01,
    StRefract = 2'b10
  } state_e;

  state_e                r_state, w_state_nxt;
  logic signed [VW-1:0]  r_vmem, w_vmem_nxt;
  logic signed [W-1:0]   r_thr, w_thr_nxt;
  logic [RCW-1:0]        r_rcnt, w_rcnt_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;

  logic                  w_accept;
  logic signed [VW-1:0]  w_leak;
  logic signed [VW:0]    w_sum;
  logic signed [VW-1:0]  w_vnext;
  logic signed [VW-1:0]  w_thr_ext;
  logic                  w_fire;

  assign in_ready = clken & (r_state == StInteg);
  assign w_accept = in_valid & in_ready;

  // One guard bit is enough: |vmem - leak| <= |vmem| and in_data is narrower than vmem.
  assign w_leak    = r_vmem >>> LEAK_SHIFT;
  assign w_sum     = {r_vmem[VW-1], r_vmem} - {w_leak[VW-1], w_leak}
                   + {{(VW+1-W){in_data[W-1]}}, in_data};
  assign w_thr_ext = {{(VW-W){r_thr[W-1]}}, r_thr};
  // Compare against the registered threshold so a same-cycle load only affects later samples.
  assign w_fire    = (w_vnext >= w_thr_ext);

  always_comb begin
    w_vnext = w_sum[VW-1:0];
    if (w_sum[VW] != w_sum[VW-1]) begin
      w_vnext = w_sum[VW] ? V_MIN : V_MAX;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vmem_nxt  = r_vmem;
    w_rcnt_nxt  = r_rcnt;
    w_cnt_nxt   = r_cnt;
    w_thr_nxt   = (thr_ld && clken) ? thr_in : r_thr;
    if (clken) begin
      unique case (r_state)
        StInteg: begin
          if (w_accept) begin
            if (w_fire) begin
              w_vmem_nxt  = V_RST;
              w_state_nxt = StFire;
            end else begin
              w_vmem_nxt = w_vnext;
            end
          end
        end
        StFire: begin
          if (r_cnt != {CNT_W{1'b1}}) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
          if (REFRAC == 0) begin
            w_state_nxt = StInteg;
          end else begin
            w_state_nxt = StRefract;
            w_rcnt_nxt  = REFRAC_INIT;
          end
        end
        StRefract: begin
          if (r_rcnt <= RCW'(1)) begin
            w_state_nxt = StInteg;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = StInteg;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StInteg;
      r_vmem  <= '0;
      r_thr   <= THR_RST;
      r_rcnt  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vmem  <= w_vmem_nxt;
      r_thr   <= w_thr_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign spike     = (r_state == StFire);
  assign vmem      = r_vmem;
  assign state     = r_state;
  assign spike_cnt = r_cnt;

endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: directed self-checking bench for lif_neuron with default parameters
// (THRESH=1000, LEAK_SHIFT=4, REFRAC=3, VW=20). Inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_lif_neuron;

  logic               clk;
  logic               rst;
  logic               clken;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               thr_ld;
  logic signed [15:0] thr_in;
  logic               spike;
  logic signed [19:0] vmem;
  logic [1:0]         state;
  logic [7:0]         spike_cnt;

  int checks = 0;
  int errors = 0;

  lif_neuron dut (
    .clk       (clk),
    .rst       (rst),
    .clken     (clken),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .thr_ld    (thr_ld),
    .thr_in    (thr_in),
    .spike     (spike),
    .vmem      (vmem),
    .state     (state),
    .spike_cnt (spike_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic signed [15:0] val);
    in_valid = 1'b1;
    in_data  = val;
    tick();
    in_valid = 1'b0;
  endtask

  longint v_model;
  longint v_prev;

  initial begin
    rst      = 1'b0;
    clken    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    thr_ld   = 1'b0;
    thr_in   = '0;
    #3;
    check("rst_vmem", vmem, 0);
    check("rst_spike", spike, 0);
    check("rst_cnt", spike_cnt, 0);
    check("rst_state", state, 0);
    #4 rst = 1'b1;
    #1;
    check("rst_ready", in_ready, 1);

    // 1: 400 -> 400, 775, then 1127 >= 1000 fires
    accept(16'sd400);
    check("t1_v1", vmem, 400);
    accept(16'sd400);
    check("t1_v2", vmem, 775);
    accept(16'sd400);
    check("t1_spike", spike, 1);
    check("t1_state_fire", state, 1);
    check("t1_vreset", vmem, 0);
    tick();
    check("t1_spike_low", spike, 0);
    check("t1_state_ref", state, 2);
    check("t1_cnt", spike_cnt, 1);
    tick();
    tick();
    check("t1_still_ref", state, 2);
    tick();
    check("t1_back_integ", state, 0);

    // 2: in_valid held through the spike is ignored for FIRE + 3 REFRACT cycles
    accept(16'sd400);
    accept(16'sd400);
    in_valid = 1'b1;
    in_data  = 16'sd400;
    tick();
    check("t2_fire", spike, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_ready_low%0d", i), in_ready, 0);
      check($sformatf("t2_vmem%0d", i), vmem, 0);
      tick();
    end
    check("t2_ready_back", in_ready, 1);
    check("t2_vmem_end", vmem, 0);
    check("t2_cnt", spike_cnt, 2);
    in_valid = 1'b0;

    // 3: long run of most-negative input never goes below -2^19 nor wraps
    v_model = 0;
    for (int i = 0; i < 200; i++) begin
      v_prev  = v_model;
      v_model = v_model - (v_model >>> 4) - 32768;
      if (v_model < -524288) v_model = -524288;
      accept(-16'sd32768);
      if (i % 20 == 0 || i == 199) begin
        check($sformatf("t3_vmem%0d", i), vmem, v_model);
        check($sformatf("t3_nonincr%0d", i), (longint'(vmem) <= v_prev) ? 1 : 0, 1);
      end
    end
    check("t3_floor", (longint'(vmem) >= -524288) ? 1 : 0, 1);
    check("t3_negative", vmem[19], 1);
    check("t3_no_spike_cnt", spike_cnt, 2);
    check("t3_state", state, 0);

    // Async reset pulse away from the edge to return to a clean start.
    #3 rst = 1'b0;
    #1 check("rst2_vmem", vmem, 0);
    #1 rst = 1'b1;
    tick();

    // clken low in INTEG: no accept, vmem holds
    clken    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'sd500;
    #1 check("cke_ready_low", in_ready, 0);
    tick();
    check("cke_vmem_hold", vmem, 0);
    in_valid = 1'b0;
    clken    = 1'b1;

    // 4: freeze for 5 cycles in REFRACT, then resume the remaining count
    accept(16'sd400);
    accept(16'sd400);
    accept(16'sd400);
    tick();
    check("t4_ref", state, 2);
    check("t4_cnt", spike_cnt, 1);
    clken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t4_frz_state%0d", i), state, 2);
      check($sformatf("t4_frz_cnt%0d", i), spike_cnt, 1);
    end
    check("t4_frz_vmem", vmem, 0);
    clken = 1'b1;
    tick();
    check("t4_res1", state, 2);
    tick();
    check("t4_res2", state, 2);
    tick();
    check("t4_res_integ", state, 0);

    // 5: threshold load with a simultaneous accept compares with the old threshold
    thr_ld   = 1'b1;
    thr_in   = 16'sd200;
    accept(16'sd300);
    thr_ld = 1'b0;
    check("t5_no_spike", spike, 0);
    check("t5_vmem", vmem, 300);
    accept(16'sd0);
    check("t5_spike", spike, 1);
    check("t5_vreset", vmem, 0);
    tick();
    check("t5_cnt", spike_cnt, 2);
    tick();
    check("t5_in_ref", state, 2);

    // 6: async reset mid-REFRACT; threshold returns to 1000
    #3 rst = 1'b0;
    #1;
    check("t6_state", state, 0);
    check("t6_cnt", spike_cnt, 0);
    check("t6_spike", spike, 0);
    check("t6_vmem", vmem, 0);
    #2 rst = 1'b1;
    tick();
    accept(16'sd300);
    accept(16'sd0);
    check("t6_thr_restored", spike, 0);
    check("t6_vmem_282", vmem, 282);
    check("t6_state_integ", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
